// File: rtl/io_access_unit.sv
// CPU in/out instruction to I/O bus bridge: one outstanding access, one bus
// handshake or one timeout per access, response held until the CPU takes it.
module io_access_unit #(
  parameter int TimeoutCycles = 65535
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_req_valid,
  output logic        o_req_ready,
  input  logic        i_req_write,
  input  logic [31:0] i_req_dev_id,
  input  logic [31:0] i_req_wdata,
  output logic        o_rsp_valid,
  input  logic        i_rsp_ready,
  output logic [31:0] o_rsp_rdata,
  output logic        o_rsp_timeout,
  output logic [31:0] o_dev_id,
  output logic        o_din_valid,
  output logic [31:0] o_din_bits,
  input  logic        i_din_ready,
  output logic        o_dout_ready,
  input  logic        i_dout_valid,
  input  logic [31:0] i_dout_bits,
  output logic [1:0]  o_dbg_state
);

  // Handshakes: a transfer happens on a rising edge where valid and ready are
  // both high; a valid, once raised, holds its payload until that edge.

  localparam int CntW = (TimeoutCycles > 0) ? $clog2(TimeoutCycles + 1) : 1;
  localparam logic [CntW-1:0] CntLast = CntW'((TimeoutCycles > 0) ? TimeoutCycles - 1 : 0);
  localparam logic [CntW-1:0] CntMax  = '1;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_RESP   = 2'd2
  } state_t;

  state_t          r_state;
  logic            r_write;
  logic [CntW-1:0] r_cnt;
  logic            r_req_ready;
  logic            r_rsp_valid;
  logic [31:0]     r_rsp_rdata;
  logic            r_rsp_timeout;
  logic [31:0]     r_dev_id;
  logic            r_din_valid;
  logic [31:0]     r_din_bits;
  logic            r_dout_ready;

  logic w_handshake;
  logic w_expire;

  assign w_handshake = r_write ? i_din_ready : i_dout_valid;
  assign w_expire    = (TimeoutCycles != 0) && (r_cnt == CntLast);

  // All bus-side outputs are registers, so the bus never sees a path from its
  // own ready/valid back into dev_id or the channel strobes.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state       <= ST_IDLE;
      r_write       <= 1'b0;
      r_cnt         <= '0;
      r_req_ready   <= 1'b1;
      r_rsp_valid   <= 1'b0;
      r_rsp_rdata   <= '0;
      r_rsp_timeout <= 1'b0;
      r_dev_id      <= '0;
      r_din_valid   <= 1'b0;
      r_din_bits    <= '0;
      r_dout_ready  <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (i_req_valid) begin
            r_state      <= ST_ACCESS;
            r_write      <= i_req_write;
            r_cnt        <= '0;
            r_req_ready  <= 1'b0;
            r_dev_id     <= i_req_dev_id;
            r_din_valid  <= i_req_write;
            r_din_bits   <= i_req_write ? i_req_wdata : 32'd0;
            r_dout_ready <= ~i_req_write;
          end
        end
        ST_ACCESS: begin
          if (w_handshake || w_expire) begin
            // A handshake on the expiry cycle still wins over the timeout.
            r_state       <= ST_RESP;
            r_rsp_valid   <= 1'b1;
            r_rsp_timeout <= ~w_handshake;
            r_rsp_rdata   <= (w_handshake && !r_write) ? i_dout_bits : 32'd0;
            r_din_valid   <= 1'b0;
            r_din_bits    <= '0;
            r_dout_ready  <= 1'b0;
          end else if (r_cnt != CntMax) begin
            r_cnt <= r_cnt + CntW'(1);
          end
        end
        ST_RESP: begin
          if (i_rsp_ready) begin
            r_state       <= ST_IDLE;
            r_req_ready   <= 1'b1;
            r_rsp_valid   <= 1'b0;
            r_rsp_rdata   <= '0;
            r_rsp_timeout <= 1'b0;
            r_dev_id      <= '0;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign o_req_ready   = r_req_ready;
  assign o_rsp_valid   = r_rsp_valid;
  assign o_rsp_rdata   = r_rsp_rdata;
  assign o_rsp_timeout = r_rsp_timeout;
  assign o_dev_id      = r_dev_id;
  assign o_din_valid   = r_din_valid;
  assign o_din_bits    = r_din_bits;
  assign o_dout_ready  = r_dout_ready;
  assign o_dbg_state   = r_state;

endmodule

// File: tb/tb_io_access_unit.sv
// Bench for io_access_unit with an 8-cycle timeout: vector table, random
// accesses and hand sequences for back-pressure and mid-access reset.
module tb_io_access_unit;

  localparam int Tmo = 8;

  logic        clk;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic        req_write;
  logic [31:0] req_dev_id;
  logic [31:0] req_wdata;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_rdata;
  logic        rsp_timeout;
  logic [31:0] dev_id;
  logic        din_valid;
  logic [31:0] din_bits;
  logic        din_ready;
  logic        dout_ready;
  logic        dout_valid;
  logic [31:0] dout_bits;
  logic [1:0]  dbg_state;

  io_access_unit #(.TimeoutCycles(Tmo)) dut (
    .i_clk(clk), .i_rst(rst),
    .i_req_valid(req_valid), .o_req_ready(req_ready),
    .i_req_write(req_write), .i_req_dev_id(req_dev_id), .i_req_wdata(req_wdata),
    .o_rsp_valid(rsp_valid), .i_rsp_ready(rsp_ready),
    .o_rsp_rdata(rsp_rdata), .o_rsp_timeout(rsp_timeout),
    .o_dev_id(dev_id), .o_din_valid(din_valid), .o_din_bits(din_bits),
    .i_din_ready(din_ready), .o_dout_ready(dout_ready),
    .i_dout_valid(dout_valid), .i_dout_bits(dout_bits),
    .o_dbg_state(dbg_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  int n_rsp    = 0;
  int n_exp_rsp = 0;
  logic [32:0] exp_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // scoreboard: a response is consumed on the edge after a negedge that sees
  // valid && ready
  always @(negedge clk) begin
    if (!rst && rsp_valid && rsp_ready) begin
      logic [32:0] e;
      n_rsp++;
      if (exp_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_rsp: got timeout=%0b rdata=0x%08h expected none", rsp_timeout, rsp_rdata);
      end else begin
        e = exp_q.pop_front();
        check("rsp_timeout", {31'd0, rsp_timeout}, {31'd0, e[32]});
        check("rsp_rdata", rsp_rdata, e[31:0]);
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Called at posedge+1 with the DUT in IDLE; returns at posedge+1 in IDLE.
  task automatic do_access(input logic wr, input logic [31:0] dev, input logic [31:0] wd,
                           input int hs, input logic [31:0] bits, input int exp_cycles,
                           input logic exp_to, input int rsp_wait, input logic hold_req);
    int n;
    logic got;
    logic [31:0] exp_rd;
    exp_rd = (exp_to || wr) ? 32'd0 : bits;
    req_valid = 1'b1; req_write = wr; req_dev_id = dev; req_wdata = wd;
    @(negedge clk);
    check("idle_req_ready", {31'd0, req_ready}, 32'd1);
    check("idle_dev_id", dev_id, 32'd0);
    @(posedge clk); #1;
    req_valid = 1'b0; req_wdata = $urandom;
    exp_q.push_back({exp_to, exp_rd});
    n_exp_rsp++;
    n = 0; got = 1'b0;
    while (!got && n < 40) begin
      if (n == hs) begin
        if (wr) din_ready = 1'b1;
        else begin dout_valid = 1'b1; dout_bits = bits; end
      end
      @(negedge clk);
      check("acc_din_valid", {31'd0, din_valid}, {31'd0, wr});
      check("acc_dout_ready", {31'd0, dout_ready}, {31'd0, ~wr});
      check("acc_din_bits", din_bits, wr ? wd : 32'd0);
      check("acc_dev_id", dev_id, dev);
      check("acc_req_ready", {31'd0, req_ready}, 32'd0);
      @(posedge clk); #1;
      din_ready = 1'b0; dout_valid = 1'b0; dout_bits = $urandom;
      n++;
      got = rsp_valid;
    end
    check("access_cycles", n, exp_cycles);
    for (int w = 0; w <= rsp_wait; w++) begin
      if (hold_req) begin
        req_valid = 1'b1; req_write = 1'b0; req_dev_id = 32'h2000;
      end
      rsp_ready = (w == rsp_wait);
      @(negedge clk);
      check("resp_valid", {31'd0, rsp_valid}, 32'd1);
      check("resp_rdata_stable", rsp_rdata, exp_rd);
      check("resp_timeout_stable", {31'd0, rsp_timeout}, {31'd0, exp_to});
      check("resp_bus_idle", {30'd0, din_valid, dout_ready}, 32'd0);
      check("resp_req_ready", {31'd0, req_ready}, 32'd0);
      check("resp_dev_id", dev_id, dev);
      @(posedge clk); #1;
    end
    rsp_ready = 1'b0;
    if (!hold_req) req_valid = 1'b0;
  endtask

  typedef struct {
    logic        wr;
    logic [31:0] dev;
    logic [31:0] wd;
    int          hs;
    logic [31:0] bits;
    int          exp_cycles;
    logic        exp_to;
  } vec_t;

  vec_t tbl[6];

  initial begin
    tbl[0] = '{1'b1, 32'h0000, 32'h41,       2, 32'h0,        3, 1'b0};
    tbl[1] = '{1'b0, 32'h1000, 32'h0,        0, 32'h12345678, 1, 1'b0};
    tbl[2] = '{1'b0, 32'h9999, 32'h0,       -1, 32'h0,        8, 1'b1};
    tbl[3] = '{1'b0, 32'h9999, 32'h0,        7, 32'hCAFEF00D, 8, 1'b0};
    tbl[4] = '{1'b1, 32'h0005, 32'hDEADBEEF, -1, 32'h0,       8, 1'b1};
    tbl[5] = '{1'b1, 32'h0006, 32'h5A5A5A5A, 7, 32'h0,        8, 1'b0};

    rst = 1'b1; req_valid = 1'b0; req_write = 1'b0; req_dev_id = '0; req_wdata = '0;
    rsp_ready = 1'b0; din_ready = 1'b0; dout_valid = 1'b0; dout_bits = '0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("rst_req_ready", {31'd0, req_ready}, 32'd1);
    check("rst_outputs", {29'd0, rsp_valid, rsp_timeout, din_valid}, 32'd0);
    check("rst_rdata", rsp_rdata, 32'd0);
    check("rst_dev_id", dev_id, 32'd0);
    check("rst_din_bits", din_bits, 32'd0);
    check("rst_dout_ready", {31'd0, dout_ready}, 32'd0);
    @(posedge clk); #1;

    for (int i = 0; i < 6; i++)
      do_access(tbl[i].wr, tbl[i].dev, tbl[i].wd, tbl[i].hs, tbl[i].bits,
                tbl[i].exp_cycles, tbl[i].exp_to, i % 2, 1'b0);

    for (int i = 0; i < 6; i++) begin
      logic wr;
      int hs;
      logic [31:0] dev, wd, bits;
      wr = 1'($urandom_range(0, 1));
      hs = int'($urandom_range(0, 10)) - 1;
      dev = $urandom; wd = $urandom; bits = $urandom;
      if (hs >= 0 && hs < Tmo) do_access(wr, dev, wd, hs, bits, hs + 1, 1'b0, int'($urandom_range(0, 2)), 1'b0);
      else do_access(wr, dev, wd, hs, bits, Tmo, 1'b1, int'($urandom_range(0, 2)), 1'b0);
    end

    // response back-pressure with the next request already pending
    do_access(1'b0, 32'h1234, 32'h0, 1, 32'h0BADF00D, 2, 1'b0, 5, 1'b1);
    do_access(1'b0, 32'h2000, 32'h0, 0, 32'h00C0FFEE, 1, 1'b0, 0, 1'b0);

    // reset in the third cycle of a write access drops it silently
    req_valid = 1'b1; req_write = 1'b1; req_dev_id = 32'h3000; req_wdata = 32'h77;
    @(posedge clk); #1;
    req_valid = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check("midrst_req_ready", {31'd0, req_ready}, 32'd1);
    check("midrst_flags", {28'd0, rsp_valid, rsp_timeout, din_valid, dout_ready}, 32'd0);
    check("midrst_dev_id", dev_id, 32'd0);
    check("midrst_din_bits", din_bits, 32'd0);
    check("midrst_rdata", rsp_rdata, 32'd0);
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      check("midrst_no_rsp", {31'd0, rsp_valid}, 32'd0);
    end
    @(posedge clk); #1;
    do_access(1'b0, 32'h4000, 32'h0, 3, 32'h87654321, 4, 1'b0, 1, 1'b0);

    repeat (3) @(posedge clk);
    check("rsp_count", n_rsp, n_exp_rsp);
    check("queue_empty", exp_q.size(), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
